// File: rtl/writeback_if.sv
// Bundle between the execute stage, data memory and the register-file write
// port of writeback_unit. The master side is the surrounding datapath.
interface writeback_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic [1:0]  in_result_src;
    logic [31:0] in_alu_result;
    logic [31:0] in_pc_plus4;
    logic [2:0]  in_funct3;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        flush;
    logic        WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic        pending_valid;
    logic [4:0]  pending_rd;

    modport master (
        output in_valid, in_rd, in_reg_write, in_result_src, in_alu_result,
               in_pc_plus4, in_funct3, mem_rvalid, mem_rdata, flush,
        input  in_ready, WE3, A3, WD3, pending_valid, pending_rd
    );

    modport slave (
        input  in_valid, in_rd, in_reg_write, in_result_src, in_alu_result,
               in_pc_plus4, in_funct3, mem_rvalid, mem_rdata, flush,
        output in_ready, WE3, A3, WD3, pending_valid, pending_rd
    );
endinterface

// File: rtl/writeback_unit.sv
// Register-file write side: takes one result per cycle, waits for load data
// where needed, extracts/extends loaded bytes and halves, drives A3/WD3/WE3.
module writeback_unit (
    input  logic        clk,
    input  logic        rst_n,
    writeback_if.slave  wb
);
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_LOAD = 2'd1;
    localparam logic [1:0] ST_COMMIT    = 2'd2;

    logic [1:0]  state_reg, state_next;
    logic [4:0]  rd_reg;
    logic        reg_write_reg;
    logic [2:0]  funct3_reg;
    logic [1:0]  offset_reg;
    logic [4:0]  a3_reg;
    logic [31:0] wd3_reg;

    logic        in_ready_int;
    logic        transfer;
    logic        is_load_in;
    logic [31:0] direct_data;
    logic [31:0] load_data;
    logic [7:0]  mem_lane [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign in_ready_int = (state_reg != ST_WAIT_LOAD);
    // A flush drops whatever is presented in the same cycle.
    assign transfer     = wb.in_valid & in_ready_int & ~wb.flush;
    assign is_load_in   = (wb.in_result_src == 2'b01);
    assign direct_data  = (wb.in_result_src == 2'b10) ? wb.in_pc_plus4 : wb.in_alu_result;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign mem_lane[gi] = wb.mem_rdata[8*gi +: 8];
        end
    endgenerate

    assign sel_byte = mem_lane[offset_reg];
    assign sel_half = offset_reg[1] ? wb.mem_rdata[31:16] : wb.mem_rdata[15:0];

    always_comb begin
        load_data = wb.mem_rdata;
        case (funct3_reg)
            3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
            3'b100:  load_data = {24'd0, sel_byte};
            3'b101:  load_data = {16'd0, sel_half};
            default: load_data = wb.mem_rdata;
        endcase
    end

    always_comb begin
        state_next = ST_IDLE;
        if (state_reg == ST_WAIT_LOAD) begin
            if (wb.flush)
                state_next = ST_IDLE;
            else if (wb.mem_rvalid)
                state_next = ST_COMMIT;
            else
                state_next = ST_WAIT_LOAD;
        end else if (transfer) begin
            state_next = is_load_in ? ST_WAIT_LOAD : ST_COMMIT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            rd_reg        <= 5'd0;
            reg_write_reg <= 1'b0;
            funct3_reg    <= 3'd0;
            offset_reg    <= 2'd0;
            a3_reg        <= 5'd0;
            wd3_reg       <= 32'd0;
        end else begin
            state_reg <= state_next;
            if (transfer) begin
                rd_reg        <= wb.in_rd;
                reg_write_reg <= wb.in_reg_write;
                if (is_load_in) begin
                    funct3_reg <= wb.in_funct3;
                    offset_reg <= wb.in_alu_result[1:0];
                end else begin
                    a3_reg  <= wb.in_rd;
                    wd3_reg <= direct_data;
                end
            end else if (state_reg == ST_WAIT_LOAD && !wb.flush && wb.mem_rvalid) begin
                a3_reg  <= rd_reg;
                wd3_reg <= load_data;
            end
        end
    end

    assign wb.in_ready      = in_ready_int;
    assign wb.WE3           = (state_reg == ST_COMMIT) & reg_write_reg & (rd_reg != 5'd0);
    assign wb.A3            = a3_reg;
    assign wb.WD3           = wd3_reg;
    assign wb.pending_valid = ((state_reg == ST_WAIT_LOAD) || (state_reg == ST_COMMIT))
                              & reg_write_reg & (rd_reg != 5'd0);
    assign wb.pending_rd    = rd_reg;
endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: hand-computed results for ALU, PC+4,
// load extraction, write suppression, flush and mid-load reset.
module tb_writeback_unit;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    writeback_if bus ();

    writeback_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "watchdog");
    end

    task automatic drive_idle();
        bus.in_valid      = 1'b0;
        bus.in_rd         = 5'd0;
        bus.in_reg_write  = 1'b0;
        bus.in_result_src = 2'b00;
        bus.in_alu_result = 32'd0;
        bus.in_pc_plus4   = 32'd0;
        bus.in_funct3     = 3'd0;
        bus.mem_rvalid    = 1'b0;
        bus.mem_rdata     = 32'd0;
        bus.flush         = 1'b0;
    endtask

    task automatic drive_in(input logic [4:0] rd, input logic rw, input logic [1:0] src,
                            input logic [31:0] alu, input logic [31:0] pc4, input logic [2:0] f3);
        bus.in_valid      = 1'b1;
        bus.in_rd         = rd;
        bus.in_reg_write  = rw;
        bus.in_result_src = src;
        bus.in_alu_result = alu;
        bus.in_pc_plus4   = pc4;
        bus.in_funct3     = f3;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        #3;
        checks++;
        if ({bus.WE3, bus.A3, bus.WD3, bus.pending_valid, bus.pending_rd, bus.in_ready} !== {1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1}) begin
            failures++;
            $display("FAIL reset_outputs: got WE3=%b A3=%0d WD3=%h pv=%b prd=%0d rdy=%b required 0 0 0 0 0 1",
                     bus.WE3, bus.A3, bus.WD3, bus.pending_valid, bus.pending_rd, bus.in_ready);
        end
        step();
        rst_n = 1'b1;
        step();
        $display("test_reset done");
    endtask

    task automatic test_alu_single();
        drive_in(5'd5, 1'b1, 2'b00, 32'h0000_0042, 32'h0000_1004, 3'd0);
        step();
        drive_idle();
        checks++;
        if ({bus.WE3, bus.A3, bus.WD3, bus.pending_valid, bus.pending_rd} !== {1'b1, 5'd5, 32'h42, 1'b1, 5'd5}) begin
            failures++;
            $display("FAIL alu_commit: got WE3=%b A3=%0d WD3=%h pv=%b prd=%0d required 1 5 00000042 1 5",
                     bus.WE3, bus.A3, bus.WD3, bus.pending_valid, bus.pending_rd);
        end
        step();
        checks++;
        if ({bus.WE3, bus.A3, bus.WD3, bus.pending_valid} !== {1'b0, 5'd5, 32'h42, 1'b0}) begin
            failures++;
            $display("FAIL alu_after: got WE3=%b A3=%0d WD3=%h pv=%b required 0 5 00000042 0",
                     bus.WE3, bus.A3, bus.WD3, bus.pending_valid);
        end
        $display("test_alu_single done");
    endtask

    task automatic test_back_to_back();
        logic [1:0]  srcs [3];
        logic [31:0] exps [3];
        srcs[0] = 2'b00; exps[0] = 32'h0000_0011;
        srcs[1] = 2'b10; exps[1] = 32'h0000_0104;
        srcs[2] = 2'b11; exps[2] = 32'h0000_0033;
        for (int i = 0; i < 3; i++) begin
            drive_in(5'(i + 1), 1'b1, srcs[i], (i == 2) ? 32'h33 : 32'h11, 32'h104, 3'd0);
            checks++;
            if (bus.in_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready[%0d]: got %b required 1", i, bus.in_ready);
            end
            step();
            checks++;
            if ({bus.WE3, bus.A3, bus.WD3} !== {1'b1, 5'(i + 1), exps[i]}) begin
                failures++;
                $display("FAIL b2b_write[%0d]: got WE3=%b A3=%0d WD3=%h required 1 %0d %h",
                         i, bus.WE3, bus.A3, bus.WD3, i + 1, exps[i]);
            end
        end
        drive_idle();
        step();
        checks++;
        if (bus.WE3 !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end: got WE3=%b required 0", bus.WE3);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] rdata, input int delay, input logic [31:0] exp);
        drive_in(5'd9, 1'b1, 2'b01, addr, 32'h0, f3);
        step();
        drive_idle();
        for (int d = 0; d < delay; d++) begin
            bus.mem_rdata = 32'hDEAD_BEEF;
            checks++;
            if ({bus.in_ready, bus.WE3, bus.pending_valid, bus.pending_rd} !== {1'b0, 1'b0, 1'b1, 5'd9}) begin
                failures++;
                $display("FAIL %s_wait[%0d]: got rdy=%b WE3=%b pv=%b prd=%0d required 0 0 1 9",
                         name, d, bus.in_ready, bus.WE3, bus.pending_valid, bus.pending_rd);
            end
            step();
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rdata;
        step();
        drive_idle();
        checks++;
        if ({bus.WE3, bus.A3, bus.WD3, bus.in_ready} !== {1'b1, 5'd9, exp, 1'b1}) begin
            failures++;
            $display("FAIL %s_data: got WE3=%b A3=%0d WD3=%h rdy=%b required 1 9 %h 1",
                     name, bus.WE3, bus.A3, bus.WD3, bus.in_ready, exp);
        end
        step();
        checks++;
        if (bus.WE3 !== 1'b0) begin
            failures++;
            $display("FAIL %s_after: got WE3=%b required 0", name, bus.WE3);
        end
        $display("test_load %s done", name);
    endtask

    task automatic test_suppress();
        drive_in(5'd0, 1'b1, 2'b00, 32'h1111, 32'h0, 3'd0);
        step();
        drive_in(5'd7, 1'b0, 2'b00, 32'h2222, 32'h0, 3'd0);
        checks++;
        if ({bus.WE3, bus.pending_valid} !== 2'b00) begin
            failures++;
            $display("FAIL supp_x0: got WE3=%b pv=%b required 0 0", bus.WE3, bus.pending_valid);
        end
        step();
        // load to x0 must still wait for its data
        drive_in(5'd0, 1'b1, 2'b01, 32'h0, 32'h0, 3'b010);
        checks++;
        if ({bus.WE3, bus.pending_valid, bus.A3} !== {2'b00, 5'd7}) begin
            failures++;
            $display("FAIL supp_nowrite: got WE3=%b pv=%b A3=%0d required 0 0 7",
                     bus.WE3, bus.pending_valid, bus.A3);
        end
        step();
        drive_idle();
        checks++;
        if ({bus.in_ready, bus.pending_valid, bus.WE3} !== 3'b000) begin
            failures++;
            $display("FAIL supp_load_x0_wait: got rdy=%b pv=%b WE3=%b required 0 0 0",
                     bus.in_ready, bus.pending_valid, bus.WE3);
        end
        bus.mem_rvalid = 1'b1;
        step();
        drive_idle();
        checks++;
        if ({bus.in_ready, bus.WE3} !== 2'b10) begin
            failures++;
            $display("FAIL supp_load_x0_done: got rdy=%b WE3=%b required 1 0", bus.in_ready, bus.WE3);
        end
        step();
        $display("test_suppress done");
    endtask

    task automatic test_flush();
        drive_in(5'd10, 1'b1, 2'b01, 32'h0, 32'h0, 3'b010);
        step();
        drive_in(5'd11, 1'b1, 2'b00, 32'hDEAD, 32'h0, 3'd0);
        bus.flush = 1'b1;
        step();
        drive_idle();
        checks++;
        if ({bus.in_ready, bus.pending_valid, bus.WE3} !== 3'b100) begin
            failures++;
            $display("FAIL flush_wait_idle: got rdy=%b pv=%b WE3=%b required 1 0 0",
                     bus.in_ready, bus.pending_valid, bus.WE3);
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h5555_5555;
        step();
        drive_idle();
        checks++;
        if ({bus.WE3, bus.WD3} !== {1'b0, 32'h0000_0033}) begin
            failures++;
            $display("FAIL flush_stray_rvalid: got WE3=%b WD3=%h required 0 00000033", bus.WE3, bus.WD3);
        end
        // flush while a COMMIT write is on the port: that write completes
        drive_in(5'd12, 1'b1, 2'b00, 32'h0000_0C0C, 32'h0, 3'd0);
        step();
        drive_in(5'd13, 1'b1, 2'b00, 32'h0000_0D0D, 32'h0, 3'd0);
        bus.flush = 1'b1;
        checks++;
        if ({bus.WE3, bus.A3, bus.WD3} !== {1'b1, 5'd12, 32'h0C0C}) begin
            failures++;
            $display("FAIL flush_commit: got WE3=%b A3=%0d WD3=%h required 1 12 00000c0c",
                     bus.WE3, bus.A3, bus.WD3);
        end
        step();
        drive_idle();
        checks++;
        if ({bus.WE3, bus.A3} !== {1'b0, 5'd12}) begin
            failures++;
            $display("FAIL flush_dropped: got WE3=%b A3=%0d required 0 12", bus.WE3, bus.A3);
        end
        $display("test_flush done");
    endtask

    task automatic test_reset_mid_load();
        drive_in(5'd14, 1'b1, 2'b01, 32'h0, 32'h0, 3'b010);
        step();
        drive_idle();
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_pre_wait: got rdy=%b required 0", bus.in_ready);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.WE3, bus.A3, bus.WD3, bus.pending_valid, bus.pending_rd, bus.in_ready} !== {1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1}) begin
            failures++;
            $display("FAIL rst_mid_load: got WE3=%b A3=%0d WD3=%h pv=%b prd=%0d rdy=%b required 0 0 0 0 0 1",
                     bus.WE3, bus.A3, bus.WD3, bus.pending_valid, bus.pending_rd, bus.in_ready);
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hAAAA_AAAA;
        step();
        rst_n = 1'b1;
        step();
        step();
        drive_idle();
        checks++;
        if ({bus.WE3, bus.A3, bus.WD3, bus.in_ready} !== {1'b0, 5'd0, 32'd0, 1'b1}) begin
            failures++;
            $display("FAIL rst_stray_rvalid: got WE3=%b A3=%0d WD3=%h rdy=%b required 0 0 0 1",
                     bus.WE3, bus.A3, bus.WD3, bus.in_ready);
        end
        $display("test_reset_mid_load done");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_alu_single();
        test_back_to_back();
        test_load("lb",   3'b000, 32'h0000_1003, 32'h80FF_1234, 3, 32'hFFFF_FF80);
        test_load("lbu",  3'b100, 32'h0000_1003, 32'h80FF_1234, 3, 32'h0000_0080);
        test_load("lhu",  3'b101, 32'h0000_1002, 32'h80FF_1234, 2, 32'h0000_80FF);
        test_load("lh",   3'b001, 32'h0000_1003, 32'h80FF_1234, 1, 32'hFFFF_80FF);
        test_load("lw",   3'b010, 32'h0000_1000, 32'h80FF_1234, 0, 32'h80FF_1234);
        test_load("lb1",  3'b000, 32'h0000_1001, 32'h80FF_1234, 1, 32'h0000_0012);
        test_load("lh_lo",3'b001, 32'h0000_1001, 32'h0000_9234, 0, 32'hFFFF_9234);
        test_load("f3_7", 3'b111, 32'h0000_1003, 32'h1234_5678, 0, 32'h1234_5678);
        test_suppress();
        test_back_to_back();
        test_flush();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/writeback_unit.md
# writeback_unit

Register-file write side of the datapath: accepts one completed instruction result per cycle from the execute stage, waits for load data from data memory where needed, extracts and extends loaded bytes/halfwords, and drives the register-file write port (A3, WD3, WE3). It sits between the ALU/data-memory outputs and the register file, and reports the pending destination register for hazard/stall logic.

## Interface

- No parameters; data width fixed at 32, register index fixed at 5.
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  execute stage presents a result this cycle
- in_ready  output  1  unit accepts the presented result this cycle
- in_rd  input  5  destination register index
- in_reg_write  input  1  instruction writes a register
- in_result_src  input  2  00 ALUResult, 01 load data, 10 PC+4, 11 treated as 00
- in_alu_result  input  32  ALUResult; for loads, the effective address
- in_pc_plus4  input  32  PC+4 for jump-and-link
- in_funct3  input  3  load width/sign code
- mem_rvalid  input  1  data memory read data valid
- mem_rdata  input  32  data memory word, little-endian
- flush  input  1  discard any held load and any coincident input
- WE3  output  1  register-file write enable
- A3  output  5  register-file write index
- WD3  output  32  register-file write data
- pending_valid  output  1  a held instruction will write a nonzero register
- pending_rd  output  5  destination of the held instruction

## Operation

- States: IDLE (empty), WAIT_LOAD (load held, awaiting data), COMMIT (write data final, write port driven).
- in_ready = 1 in IDLE and COMMIT, 0 in WAIT_LOAD. Transfer occurs when in_valid & in_ready.
- IDLE/COMMIT + transfer, src 00/10/11 -> COMMIT with data = in_alu_result or in_pc_plus4.
- IDLE/COMMIT + transfer, src 01 -> WAIT_LOAD; latch rd, reg_write, funct3, address[1:0].
- IDLE/COMMIT, no transfer -> IDLE.
- WAIT_LOAD + mem_rvalid -> COMMIT with extracted data; no mem_rvalid -> stay.
- mem_rvalid outside WAIT_LOAD ignored.
- Load extraction, byte offset = addr[1:0]: 000 LB sign-extend byte[offset]; 001 LH sign-extend half[addr[1]]; 010 LW full word; 100 LBU zero-extend byte; 101 LHU zero-extend half; 011/110/111 full word. addr[0] ignored for halves; no misalignment trap.
- Write suppression: WE3 = (state==COMMIT) & held reg_write & (held rd != 0). Suppressed instructions still traverse states, so loads to x0 still wait for mem_rvalid.
- A3/WD3 reflect the held entry in COMMIT; hold last values otherwise.
- pending_valid = state!=IDLE & reg_write & rd!=0; pending_rd = held rd.
- flush: next state IDLE regardless of state or in_valid; coincident input dropped; a COMMIT write already on the port in the flush cycle still completes.

## Timing

- Reset (async assert, sync release): state IDLE, WE3=0, A3=0, WD3=0, pending_valid=0, pending_rd=0; in_ready=1.
- Non-load latency: accepted in cycle N -> WE3 high in cycle N+1 for exactly one cycle.
- Load latency: mem_rvalid in cycle M (M >= N+1) -> WE3 in cycle M+1.
- Throughput: one non-load per cycle back-to-back; in_ready drops for every cycle spent in WAIT_LOAD.
- Register file samples WD3/A3/WE3 on the rising edge ending the COMMIT cycle.
- rst_n low mid-load: held load discarded, subsequent mem_rvalid ignored until a new load is accepted.

## Test plan

- Reset then in_valid, src 00, rd=5, alu_result=0x0000_0042 -> next cycle WE3=1, A3=5, WD3=0x42; following cycle WE3=0.
- Three back-to-back ALU results rd=1,2,3 -> WE3 high three consecutive cycles, A3 1,2,3 in order; in_ready held 1.
- Load LB, addr 0x...03, mem_rvalid after 3 cycles with rdata 0x80FF_1234 -> in_ready=0 for those cycles, then WD3=0xFFFF_FF80; repeat LBU -> 0x0000_0080, LHU addr[1]=1 -> 0x0000_80FF, LH -> 0xFFFF_80FF.
- rd=0 with reg_write=1, and rd=7 with reg_write=0 -> WE3 never asserts; pending_valid stays 0.
- flush during WAIT_LOAD with in_valid high -> IDLE next cycle, later mem_rvalid produces no write, dropped input never written.
- rst_n pulsed low in WAIT_LOAD -> outputs zero immediately, in_ready=1, stray mem_rvalid ignored.
